egm_stim_scheduler: RTL and testbench
=====================================

Name: egm_stim_scheduler

Overview:
Avalon-MM slave controller that sequences the EGM stimulus/response interface.
- Runs a programmed number of timed trials: drives a stimulus pulse, then measures the latency to the response rising edge in microseconds.
- Accumulates results and raises an interrupt when the session ends.
- Sits in the Qsys system between the Nios II data master and the egm_interface conduit pins.

Parameters:
TICK_DIV, 50, clk cycles per 1 us tick (50 MHz clk)
LAT_W, 16, width of latency/interval/pulse/timeout fields (saturating)
TIMEOUT_US, 2000, microseconds after stimulus rise before a trial is declared a miss

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
avs_address  in  4  word address
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_read  in  1  read strobe
avs_readdata  out  32  read data, registered, read latency 1
irq  out  1  level interrupt, session done and irq_en set
egm_stimulus  out  1  stimulus pulse to EGM
egm_response  in  1  asynchronous response from EGM
egm_leds  out  4  status LEDs: [0] busy, [1] stimulus, [2] response_seen, [3] done

Behaviour:
- Reset: FSM=IDLE. All outputs and registers 0 except NUM_TRIALS=1, INTERVAL_US=1000, PULSE_US=100.
- egm_response passes through a 2-FF synchronizer. A rising edge of the synchronized signal is a "hit".
- The us tick counter free-runs mod TICK_DIV. It is cleared on every FSM state entry, so all durations are exact multiples of TICK_DIV cycles.

Register map (word address):
- 0 CTRL: W bit0 start (self-clearing pulse), bit1 abort (pulse), bit2 irq_en (stored). R returns irq_en in bit2.
- 1 STATUS: R bit0 busy, bit1 done, bit2 any_miss, [15:8] trial index. Write-1 to bit1 clears done and irq.
- 2 NUM_TRIALS [7:0].
- 3 INTERVAL_US.
- 4 PULSE_US.
- 5 LAST_LATENCY (R).
- 6 LAT_SUM [31:0] (R).
- 7 MISS_COUNT [7:0] (R).
- 8/9 see optional feature.
- Unmapped addresses read 0. Writes to addresses 2-4 while busy are ignored.

FSM:
- IDLE --start--> clears LAT_SUM, MISS_COUNT, trial index, done.
  - NUM_TRIALS=0: next state DONE, no pulse.
  - Otherwise: next state WAIT.
- WAIT: count INTERVAL_US ticks, then go to PULSE. egm_stimulus is asserted on the first PULSE cycle, and the latency counter starts at 0.
- PULSE: stimulus high for PULSE_US ticks (PULSE_US=0 treated as 1), then go to LISTEN.
  - The latency counter keeps running.
  - A hit during PULSE is recorded: latency is latched, and at PULSE end the FSM goes to NEXT.
- LISTEN: stimulus low. Waits for a hit or for the latency counter to reach TIMEOUT_US.
  - Hit: LAST_LATENCY = count, LAT_SUM += count.
  - Timeout: LAST_LATENCY = all ones, MISS_COUNT++, any_miss=1.
- NEXT (1 cycle): trial index++. If index == NUM_TRIALS go to DONE, else go to WAIT.
- DONE (1 cycle): done=1, go to IDLE.

Other rules:
- Latency counter saturates at 2^LAT_W-1. LAT_SUM wraps mod 2^32.
- Hits outside PULSE/LISTEN are ignored. A response already high at stimulus rise does not count; an edge is required.
- start while busy is ignored.
- abort in any state: next cycle FSM=IDLE, egm_stimulus=0, done unchanged, statistics retained. If start and abort arrive in the same write, abort wins.
- irq = done & irq_en, combinational from registers, glitch-free.
- reset mid-trial: stimulus drops on the next edge, all state returns to reset values.

Optional Feature:
EGM_MINMAX_EN
- Defined: adds MIN_LAT (addr 8, reset all ones) and MAX_LAT (addr 9, reset 0). Both are updated on every hit and cleared to their reset values on start. Misses do not update them.
- Undefined: no min/max registers; addresses 8/9 read 0.

Test Plan:
- NUM_TRIALS=3, INTERVAL_US=10, PULSE_US=5, response rises 1000 cycles after each stimulus rise -> LAST_LATENCY=20, LAT_SUM=60, MISS_COUNT=0, done=1, irq=1 with irq_en.
- Response held low, NUM_TRIALS=2 -> each LISTEN ends at 2000 us; MISS_COUNT=2, LAST_LATENCY=0xFFFF, any_miss=1.
- NUM_TRIALS=0, start -> done set 2 cycles after the write, egm_stimulus never asserts.
- Abort 3 cycles into PULSE -> egm_stimulus low next cycle, busy=0, done=0; a later start runs normally.
- Start rewritten while busy, plus a write to NUM_TRIALS while busy -> both ignored, session finishes with the original count.
- EGM_MINMAX_EN defined, latencies 5/30/12 us -> MIN_LAT=5, MAX_LAT=30; undefined -> addresses 8/9 read 0.

Source files
------------

// File: rtl/egm_stim_scheduler.sv
// EGM stimulus/response trial scheduler, Avalon-MM slave.
// Optional EGM_MINMAX_EN adds MIN_LAT/MAX_LAT at word addresses 8/9.
module egm_stim_scheduler #(
  parameter int TICK_DIV   = 50,
  parameter int LAT_W      = 16,
  parameter int TIMEOUT_US = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        irq,
  output logic        egm_stimulus,
  input  logic        egm_response,
  output logic [3:0]  egm_leds
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [LAT_W-1:0] LAT_ONES = '1;
  localparam logic [LAT_W-1:0] TO_LIM = LAT_W'(TIMEOUT_US);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PULSE,
    S_LISTEN,
    S_NEXT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [TW-1:0]    tick_q;
  logic [LAT_W-1:0] us_q;
  logic [LAT_W-1:0] lat_q;
  logic [7:0]       num_q;
  logic [7:0]       idx_q;
  logic [7:0]       miss_q;
  logic [LAT_W-1:0] intv_q;
  logic [LAT_W-1:0] pulse_q;
  logic [LAT_W-1:0] last_q;
  logic [31:0]      sum_q;
  logic             irq_en_q;
  logic             done_q;
  logic             any_miss_q;
  logic             seen_q;
  logic             stim_q;
  logic             busy_q;
  logic [2:0]       sync_q;
  logic [31:0]      rdata_d;
  logic [31:0]      rdata_q;

  logic             busy;
  logic             wr_ctrl;
  logic             wr_cfg;
  logic             start;
  logic             abort;
  logic             clr_done;
  logic             tick;
  logic             entry;
  logic             pulse_entry;
  logic             listening;
  logic             hit;
  logic             timeout;
  logic             wait_done;
  logic             pulse_done;
  logic [LAT_W:0]   us_inc;
  logic [LAT_W-1:0] pulse_len;
  logic [8:0]       idx_inc;
  logic             unused_wd;

  assign busy        = (state_q != S_IDLE);
  assign wr_ctrl     = avs_write && (avs_address == 4'd0);
  assign wr_cfg      = avs_write && !busy;
  assign abort       = wr_ctrl && avs_writedata[1];
  assign start       = wr_ctrl && avs_writedata[0]
                    && !avs_writedata[1] && !busy;
  assign clr_done    = avs_write && (avs_address == 4'd1)
                    && avs_writedata[1];
  assign tick        = (tick_q == TICK_LAST);
  assign entry       = (state_d != state_q);
  assign pulse_entry = (state_d == S_PULSE)
                    && (state_q != S_PULSE);
  assign listening   = (state_q == S_PULSE)
                    || (state_q == S_LISTEN);
  assign hit         = listening && sync_q[1] && !sync_q[2]
                    && !seen_q && !abort;
  assign timeout     = (state_q == S_LISTEN) && !hit
                    && (lat_q >= TO_LIM) && !abort;
  assign us_inc      = {1'b0, us_q} + 1'b1;
  assign pulse_len   = (pulse_q == '0) ? LAT_W'(1) : pulse_q;
  assign wait_done   = (intv_q == '0)
                    || (tick && us_inc == {1'b0, intv_q});
  assign pulse_done  = tick && (us_inc == {1'b0, pulse_len});
  assign idx_inc     = {1'b0, idx_q} + 9'd1;
  assign unused_wd   = ^avs_writedata;

  assign irq          = done_q & irq_en_q;
  assign egm_stimulus = stim_q;
  assign egm_leds     = {done_q, seen_q, stim_q, busy_q};
  assign avs_readdata = rdata_q;

  // Two-stage synchronizer plus one stage of history for edge detect
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], egm_response};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; abort overrides every transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start)
          state_d = (num_q == 8'd0) ? S_DONE : S_WAIT;
      S_WAIT:
        if (wait_done) state_d = S_PULSE;
      S_PULSE:
        if (pulse_done)
          state_d = (seen_q || hit) ? S_NEXT : S_LISTEN;
      S_LISTEN:
        if (hit || timeout) state_d = S_NEXT;
      S_NEXT:
        state_d = (idx_inc == {1'b0, num_q}) ? S_DONE : S_WAIT;
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Microsecond timebase, restarted on every state entry
  always_ff @(posedge clk) begin
    if (reset || entry) begin
      tick_q <= '0;
      us_q   <= '0;
    end else if (tick) begin
      tick_q <= '0;
      us_q   <= us_inc[LAT_W-1:0];
    end else begin
      tick_q <= tick_q + 1'b1;
    end
  end

  // Saturating latency counter, zeroed as the pulse begins
  always_ff @(posedge clk) begin
    if (reset || pulse_entry)
      lat_q <= '0;
    else if (tick && listening && lat_q != LAT_ONES)
      lat_q <= lat_q + 1'b1;
  end

  // Registered stimulus and busy so the pins never glitch
  always_ff @(posedge clk) begin
    if (reset) begin
      stim_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      stim_q <= (state_d == S_PULSE);
      busy_q <= (state_d != S_IDLE);
    end
  end

  // Host-writable configuration
  always_ff @(posedge clk) begin
    if (reset) begin
      num_q    <= 8'd1;
      intv_q   <= LAT_W'(1000);
      pulse_q  <= LAT_W'(100);
      irq_en_q <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= avs_writedata[2];
      if (wr_cfg && avs_address == 4'd2)
        num_q <= avs_writedata[7:0];
      if (wr_cfg && avs_address == 4'd3)
        intv_q <= avs_writedata[LAT_W-1:0];
      if (wr_cfg && avs_address == 4'd4)
        pulse_q <= avs_writedata[LAT_W-1:0];
    end
  end

  // Session statistics and trial bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q     <= '0;
      sum_q      <= '0;
      miss_q     <= '0;
      idx_q      <= '0;
      any_miss_q <= 1'b0;
      done_q     <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      if (start) begin
        sum_q      <= '0;
        miss_q     <= '0;
        idx_q      <= '0;
        any_miss_q <= 1'b0;
      end
      if (pulse_entry) seen_q <= 1'b0;
      if (hit) begin
        seen_q <= 1'b1;
        last_q <= lat_q;
        sum_q  <= sum_q + 32'(lat_q);
      end
      if (timeout) begin
        last_q     <= LAT_ONES;
        miss_q     <= miss_q + 8'd1;
        any_miss_q <= 1'b1;
      end
      if (state_q == S_NEXT && !abort) idx_q <= idx_inc[7:0];
      if (state_q == S_DONE && !abort) done_q <= 1'b1;
      else if (start || clr_done)      done_q <= 1'b0;
    end
  end

`ifdef EGM_MINMAX_EN
  logic [LAT_W-1:0] min_q;
  logic [LAT_W-1:0] max_q;

  // Per-session latency extremes, hits only
  always_ff @(posedge clk) begin
    if (reset || start) begin
      min_q <= LAT_ONES;
      max_q <= '0;
    end else if (hit) begin
      if (lat_q < min_q) min_q <= lat_q;
      if (lat_q > max_q) max_q <= lat_q;
    end
  end
`endif

  // Read mux
  always_comb begin
    rdata_d = '0;
    case (avs_address)
      4'd0: rdata_d = {29'd0, irq_en_q, 2'b00};
      4'd1: rdata_d = {16'd0, idx_q, 5'd0,
                       any_miss_q, done_q, busy};
      4'd2: rdata_d = {24'd0, num_q};
      4'd3: rdata_d = 32'(intv_q);
      4'd4: rdata_d = 32'(pulse_q);
      4'd5: rdata_d = 32'(last_q);
      4'd6: rdata_d = sum_q;
      4'd7: rdata_d = {24'd0, miss_q};
`ifdef EGM_MINMAX_EN
      4'd8: rdata_d = 32'(min_q);
      4'd9: rdata_d = 32'(max_q);
`endif
      default: rdata_d = '0;
    endcase
  end

  // Read data register, one cycle latency
  always_ff @(posedge clk) begin
    if (reset)         rdata_q <= '0;
    else if (avs_read) rdata_q <= rdata_d;
    else               rdata_q <= '0;
  end

endmodule

// File: tb/tb_egm_stim_scheduler.sv
// Directed bench for egm_stim_scheduler.
// Timeout shortened to 100 us to keep sessions short.
module tb_egm_stim_scheduler;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        irq;
  logic        egm_stimulus;
  logic        egm_response = 1'b0;
  logic [3:0]  egm_leds;

  int nchk = 0;
  int nerr = 0;
  int delays[$];
  int rsp_d;
  logic stim_seen = 1'b0;
  logic [31:0] v;

  egm_stim_scheduler #(
    .TICK_DIV  (50),
    .LAT_W     (16),
    .TIMEOUT_US(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .avs_address  (avs_address),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_read     (avs_read),
    .avs_readdata (avs_readdata),
    .irq          (irq),
    .egm_stimulus (egm_stimulus),
    .egm_response (egm_response),
    .egm_leds     (egm_leds)
  );

  always #5 clk = ~clk;

  always @(posedge egm_stimulus) stim_seen = 1'b1;

  // Response model: rise a queued number of cycles after each stimulus rise
  always begin
    @(posedge egm_stimulus);
    if (delays.size() != 0) begin
      rsp_d = delays.pop_front();
      repeat (rsp_d) @(posedge clk);
      #1 egm_response = 1'b1;
      repeat (100) @(posedge clk);
      #1 egm_response = 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    d = avs_readdata;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!egm_leds[3] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(egm_leds[3]), 32'd1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_stim", 32'(egm_stimulus), 32'd0);
    chk("rst_leds", 32'(egm_leds), 32'd0);
    rd(4'd2, v); chk("rst_num", v, 32'd1);
    rd(4'd3, v); chk("rst_intv", v, 32'd1000);
    rd(4'd4, v); chk("rst_pulse", v, 32'd100);
    rd(4'd1, v); chk("rst_status", v, 32'd0);
    rd(4'd6, v); chk("rst_sum", v, 32'd0);
    rd(4'd12, v); chk("unmapped", v, 32'd0);
`ifdef EGM_MINMAX_EN
    rd(4'd8, v); chk("rst_min", v, 32'h0000ffff);
    rd(4'd9, v); chk("rst_max", v, 32'd0);
`endif

    wr(4'd0, 32'h3);
    chk("abort_beats_start", 32'(egm_leds[0]), 32'd0);

    // Three hits at 20 us
    wr(4'd2, 32'd3);
    wr(4'd3, 32'd10);
    wr(4'd4, 32'd5);
    repeat (3) delays.push_back(1000);
    wr(4'd0, 32'h5);
    chk("s1_busy", 32'(egm_leds[0]), 32'd1);
    wait_done("s1_done", 10000);
    chk("s1_irq", 32'(irq), 32'd1);
    rd(4'd5, v); chk("s1_last", v, 32'd20);
    rd(4'd6, v); chk("s1_sum", v, 32'd60);
    rd(4'd7, v); chk("s1_miss", v, 32'd0);
    rd(4'd1, v); chk("s1_status", v, 32'h0302);
    rd(4'd0, v); chk("s1_ctrl", v, 32'h4);
    wr(4'd1, 32'h2);
    chk("s1_irq_clr", 32'(irq), 32'd0);

    // Two misses
    wr(4'd2, 32'd2);
    wr(4'd0, 32'h5);
    wait_done("s2_done", 20000);
    rd(4'd7, v); chk("s2_miss", v, 32'd2);
    rd(4'd5, v); chk("s2_last", v, 32'h0000ffff);
    rd(4'd6, v); chk("s2_sum", v, 32'd0);
    rd(4'd1, v); chk("s2_status", v, 32'h0206);

    // Zero trials: done two cycles after the write, no pulse
    wr(4'd2, 32'd0);
    stim_seen = 1'b0;
    @(negedge clk);
    avs_address   = 4'd0;
    avs_writedata = 32'h5;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    chk("s3_done_early", 32'(egm_leds[3]), 32'd0);
    @(negedge clk);
    chk("s3_done", 32'(egm_leds[3]), 32'd1);
    repeat (20) @(negedge clk);
    chk("s3_no_stim", 32'(stim_seen), 32'd0);
    rd(4'd1, v); chk("s3_status", v & 32'hff03, 32'h0002);

    // Abort three cycles into the pulse
    wr(4'd1, 32'h2);
    wr(4'd2, 32'd1);
    wr(4'd0, 32'h5);
    n = 0;
    while (!egm_stimulus && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("s4_pulse", 32'(egm_stimulus), 32'd1);
    @(negedge clk);
    wr(4'd0, 32'h6);
    chk("s4_stim_low", 32'(egm_stimulus), 32'd0);
    chk("s4_not_busy", 32'(egm_leds[0]), 32'd0);
    chk("s4_not_done", 32'(egm_leds[3]), 32'd0);
    rd(4'd1, v); chk("s4_status", v & 32'h3, 32'd0);
    delays.push_back(1000);
    wr(4'd0, 32'h5);
    wait_done("s4_rerun_done", 5000);
    rd(4'd5, v); chk("s4_last", v, 32'd20);
    rd(4'd6, v); chk("s4_sum", v, 32'd20);
    chk("s4_irq", 32'(irq), 32'd1);

    // Writes while busy are ignored
    wr(4'd1, 32'h2);
    wr(4'd2, 32'd2);
    repeat (2) delays.push_back(1000);
    wr(4'd0, 32'h5);
    repeat (20) @(negedge clk);
    wr(4'd0, 32'h5);
    wr(4'd2, 32'd5);
    rd(4'd2, v); chk("s5_num_held", v, 32'd2);
    wait_done("s5_done", 10000);
    rd(4'd1, v); chk("s5_index", (v >> 8) & 32'hff, 32'd2);
    rd(4'd6, v); chk("s5_sum", v, 32'd40);

    // Latencies 5, 30, 12 us
    wr(4'd2, 32'd3);
    delays.push_back(250);
    delays.push_back(1500);
    delays.push_back(600);
    wr(4'd0, 32'h5);
    wait_done("s6_done", 12000);
    rd(4'd5, v); chk("s6_last", v, 32'd12);
    rd(4'd6, v); chk("s6_sum", v, 32'd47);
`ifdef EGM_MINMAX_EN
    rd(4'd8, v); chk("s6_min", v, 32'd5);
    rd(4'd9, v); chk("s6_max", v, 32'd30);
`else
    rd(4'd8, v); chk("s6_addr8", v, 32'd0);
    rd(4'd9, v); chk("s6_addr9", v, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
